// File: rtl/stage3_ex_mdu_if.sv
// ID->EX->MEM handshake bundle for the execute stage.
// The master drives the ID-side fields and out_ready; the slave is the EX stage.
interface stage3_ex_mdu_if #(
  parameter int XLEN  = 32,
  parameter int REGAW = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             branch;
  logic             memread;
  logic             memwrite;
  logic             memtoreg;
  logic             regwrite;
  logic [XLEN-1:0]  pc4;
  logic             alusrc;
  logic [XLEN-1:0]  data1;
  logic [XLEN-1:0]  data2;
  logic [XLEN-1:0]  seimm;
  logic [3:0]       aluctl;
  logic [2:0]       mdu_op;
  logic             regdst;
  logic [REGAW-1:0] rt;
  logic [REGAW-1:0] rd;
  logic             out_valid;
  logic             out_ready;
  logic             branch_out;
  logic             memread_out;
  logic             memwrite_out;
  logic             memtoreg_out;
  logic             regwrite_out;
  logic [XLEN-1:0]  btarget;
  logic [XLEN-1:0]  alurslt;
  logic             zero;
  logic [XLEN-1:0]  data2_out;
  logic [REGAW-1:0] wrreg_out;
  logic             mdu_busy;

  modport master (
    output in_valid, flush, branch, memread, memwrite, memtoreg, regwrite,
    output pc4, alusrc, data1, data2, seimm, aluctl, mdu_op, regdst, rt, rd,
    output out_ready,
    input  in_ready, out_valid, branch_out, memread_out, memwrite_out,
    input  memtoreg_out, regwrite_out, btarget, alurslt, zero, data2_out,
    input  wrreg_out, mdu_busy
  );

  modport slave (
    input  in_valid, flush, branch, memread, memwrite, memtoreg, regwrite,
    input  pc4, alusrc, data1, data2, seimm, aluctl, mdu_op, regdst, rt, rd,
    input  out_ready,
    output in_ready, out_valid, branch_out, memread_out, memwrite_out,
    output memtoreg_out, regwrite_out, btarget, alurslt, zero, data2_out,
    output wrreg_out, mdu_busy
  );
endinterface

// File: rtl/stage3_ex_mdu.sv
// Execute stage: ALU, branch target, EX/MEM valid/ready register and a
// bit-serial unsigned multiply/divide unit with HI/LO registers.
module stage3_ex_mdu #(
  parameter int XLEN  = 32,
  parameter int REGAW = 5
) (
  input logic             clk,
  input logic             rst_n,
  stage3_ex_mdu_if.slave  ex
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_MFHI  = 3'b011;
  localparam logic [2:0] OP_MFLO  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [XLEN-1:0]  r_ph;
  logic [XLEN-1:0]  r_pl;
  logic [XLEN-1:0]  r_opb;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;

  logic             r_out_valid;
  logic             r_branch, r_memread, r_memwrite, r_memtoreg, r_regwrite;
  logic [XLEN-1:0]  r_btarget;
  logic [XLEN-1:0]  r_alurslt;
  logic             r_zero;
  logic [XLEN-1:0]  r_data2;
  logic [REGAW-1:0] r_wrreg;

  function automatic logic [XLEN-1:0] f_alu(input logic [3:0] ctl,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    case (ctl)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: res = a + b;
      4'b0110: res = a - b;
      4'b0111: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1100: res = ~(a | b);
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  logic w_mdu_op_any;
  logic w_conflict;
  logic w_in_ready;
  logic w_accept;
  logic w_start_mul;
  logic w_start_div;
  logic w_last;

  assign w_mdu_op_any = (ex.mdu_op == OP_MULTU) | (ex.mdu_op == OP_DIVU) |
                        (ex.mdu_op == OP_MFHI)  | (ex.mdu_op == OP_MFLO);
  assign w_conflict   = r_busy & w_mdu_op_any;
  assign w_in_ready   = ~w_conflict & (~r_out_valid | ex.out_ready);
  assign w_accept     = ex.in_valid & w_in_ready;
  assign w_start_mul  = w_accept & ~ex.flush & (ex.mdu_op == OP_MULTU);
  assign w_start_div  = w_accept & ~ex.flush & (ex.mdu_op == OP_DIVU);
  assign w_last       = (r_cnt == CW'(XLEN - 1));

  // Shift-add step: r_ph accumulates the high half, r_pl shifts the multiplier out.
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN-1:0] w_mul_ph;
  logic [XLEN-1:0] w_mul_pl;
  assign w_mul_sum = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
  assign w_mul_ph  = w_mul_sum[XLEN:1];
  assign w_mul_pl  = {w_mul_sum[0], r_pl[XLEN-1:1]};

  // Restoring step: r_ph is the partial remainder, r_pl shifts dividend out / quotient in.
  // A zero divisor never restores, giving an all-ones quotient and remainder = dividend.
  logic [XLEN:0]   w_div_sh;
  logic [XLEN:0]   w_div_df;
  logic            w_div_ok;
  logic [XLEN-1:0] w_div_ph;
  logic [XLEN-1:0] w_div_pl;
  assign w_div_sh = {r_ph, r_pl[XLEN-1]};
  assign w_div_df = w_div_sh - {1'b0, r_opb};
  assign w_div_ok = ~w_div_df[XLEN];
  assign w_div_ph = w_div_ok ? w_div_df[XLEN-1:0] : w_div_sh[XLEN-1:0];
  assign w_div_pl = {r_pl[XLEN-2:0], w_div_ok};

  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_result;
  assign w_b      = ex.alusrc ? ex.seimm : ex.data2;
  assign w_alu    = f_alu(ex.aluctl, ex.data1, w_b);
  assign w_result = (ex.mdu_op == OP_MFHI) ? r_hi :
                    (ex.mdu_op == OP_MFLO) ? r_lo : w_alu;

  // MDU state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // MDU next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_mul) begin
          w_state_nxt = S_MUL;
        end else if (w_start_div) begin
          w_state_nxt = S_DIV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // MDU datapath, iteration counter and HI/LO write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= {CW{1'b0}};
      r_ph   <= {XLEN{1'b0}};
      r_pl   <= {XLEN{1'b0}};
      r_opb  <= {XLEN{1'b0}};
      r_hi   <= {XLEN{1'b0}};
      r_lo   <= {XLEN{1'b0}};
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_start_mul | w_start_div) begin
            r_cnt <= {CW{1'b0}};
            r_ph  <= {XLEN{1'b0}};
            r_pl  <= ex.data1;
            r_opb <= ex.data2;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + CW'(1);
          r_ph  <= w_mul_ph;
          r_pl  <= w_mul_pl;
          if (w_last) begin
            r_hi <= w_mul_ph;
            r_lo <= w_mul_pl;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + CW'(1);
          r_ph  <= w_div_ph;
          r_pl  <= w_div_pl;
          if (w_last) begin
            r_hi <= w_div_ph;
            r_lo <= w_div_pl;
          end
        end
        default: r_cnt <= {CW{1'b0}};
      endcase
    end
  end

  // EX/MEM pipeline register: load on accept, drain on out_ready, otherwise frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_branch    <= 1'b0;
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_regwrite  <= 1'b0;
      r_btarget   <= {XLEN{1'b0}};
      r_alurslt   <= {XLEN{1'b0}};
      r_zero      <= 1'b0;
      r_data2     <= {XLEN{1'b0}};
      r_wrreg     <= {REGAW{1'b0}};
    end else if (w_accept) begin
      r_out_valid <= ~ex.flush;
      r_branch    <= ex.branch;
      r_memread   <= ex.memread;
      r_memwrite  <= ex.memwrite;
      r_memtoreg  <= ex.memtoreg;
      r_regwrite  <= ex.regwrite;
      r_btarget   <= ex.pc4 + {ex.seimm[XLEN-3:0], 2'b00};
      r_alurslt   <= w_result;
      r_zero      <= (w_alu == {XLEN{1'b0}});
      r_data2     <= ex.data2;
      r_wrreg     <= ex.regdst ? ex.rd : ex.rt;
    end else if (ex.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign ex.in_ready     = w_in_ready;
  assign ex.out_valid    = r_out_valid;
  assign ex.branch_out   = r_branch;
  assign ex.memread_out  = r_memread;
  assign ex.memwrite_out = r_memwrite;
  assign ex.memtoreg_out = r_memtoreg;
  assign ex.regwrite_out = r_regwrite;
  assign ex.btarget      = r_btarget;
  assign ex.alurslt      = r_alurslt;
  assign ex.zero         = r_zero;
  assign ex.data2_out    = r_data2;
  assign ex.wrreg_out    = r_wrreg;
  assign ex.mdu_busy     = r_busy;

endmodule

// File: tb/tb_stage3_ex_mdu.sv
// Directed bench for stage3_ex_mdu: a transaction-level reference model
// checked every negedge, plus literal expectations from hand calculation.
module tb_stage3_ex_mdu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  stage3_ex_mdu_if #(.XLEN(32), .REGAW(5)) ex ();
  stage3_ex_mdu #(.XLEN(32), .REGAW(5)) dut (.clk(clk), .rst_n(rst_n), .ex(ex));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [4:0]  m_ctl;
  logic [31:0] m_bt, m_res, m_d2, m_hi, m_lo, m_phi, m_plo;
  logic        m_zero;
  logic [4:0]  m_wr;
  int          m_left;
  logic        m_busy, m_in_ready, m_acc;
  logic [31:0] m_b;

  assign m_busy     = (m_left > 0);
  assign m_in_ready = !(m_busy && ex.mdu_op >= 3'd1 && ex.mdu_op <= 3'd4) && (!m_valid || ex.out_ready);
  assign m_acc      = ex.in_valid && m_in_ready;
  assign m_b        = ex.alusrc ? ex.seimm : ex.data2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_ctl <= 5'd0; m_bt <= 32'd0; m_res <= 32'd0; m_d2 <= 32'd0;
      m_zero <= 1'b0; m_wr <= 5'd0; m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0;
      m_phi <= 32'd0; m_plo <= 32'd0;
    end else begin
      if (m_acc) begin
        m_valid <= !ex.flush;
        m_ctl   <= {ex.branch, ex.memread, ex.memwrite, ex.memtoreg, ex.regwrite};
        m_bt    <= ex.pc4 + ex.seimm * 32'd4;
        m_res   <= (ex.mdu_op == 3'd3) ? m_hi : (ex.mdu_op == 3'd4) ? m_lo : alu_ref(ex.aluctl, ex.data1, m_b);
        m_zero  <= (alu_ref(ex.aluctl, ex.data1, m_b) == 32'd0);
        m_d2    <= ex.data2;
        m_wr    <= ex.regdst ? ex.rd : ex.rt;
      end else if (ex.out_ready) begin
        m_valid <= 1'b0;
      end
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= m_phi;
          m_lo <= m_plo;
        end
      end else if (m_acc && !ex.flush && ex.mdu_op == 3'd1) begin
        m_left <= 32;
        {m_phi, m_plo} <= {32'd0, ex.data1} * {32'd0, ex.data2};
      end else if (m_acc && !ex.flush && ex.mdu_op == 3'd2) begin
        m_left <= 32;
        m_phi  <= (ex.data2 == 32'd0) ? ex.data1 : ex.data1 % ex.data2;
        m_plo  <= (ex.data2 == 32'd0) ? 32'hFFFF_FFFF : ex.data1 / ex.data2;
      end
    end
  end

  // Continuous comparison of DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", ex.out_valid, m_valid);
      chk("mdu_busy", ex.mdu_busy, m_busy);
      chk("in_ready", ex.in_ready, m_in_ready);
      if (m_valid) begin
        chk("alurslt", ex.alurslt, m_res);
        chk("zero", ex.zero, m_zero);
        chk("btarget", ex.btarget, m_bt);
        chk("data2_out", ex.data2_out, m_d2);
        chk("wrreg_out", ex.wrreg_out, m_wr);
        chk("ctl_out", {ex.branch_out, ex.memread_out, ex.memwrite_out, ex.memtoreg_out, ex.regwrite_out}, m_ctl);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [2:0] op, input logic [3:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic src, input logic [31:0] imm,
                       input logic [31:0] pc, input logic rdst, input logic [4:0] rdv);
    ex.mdu_op = op; ex.aluctl = ctl; ex.data1 = a; ex.data2 = b; ex.alusrc = src;
    ex.seimm = imm; ex.pc4 = pc; ex.regdst = rdst; ex.rd = rdv; ex.rt = 5'd3;
    ex.regwrite = (op == 3'd1 || op == 3'd2) ? 1'b0 : 1'b1;
    ex.branch = b[0]; ex.memread = b[1]; ex.memwrite = a[0]; ex.memtoreg = a[1];
    ex.in_valid = 1'b1;
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    setup(op, ctl, a, b, 1'b0, 32'd0, 32'h0000_1000, 1'b1, 5'd7);
    tick();
    ex.in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (ex.mdu_busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("mdu_timeout", 64'd1, 64'd0);
  endtask

  int n;
  logic [31:0] mv [8];
  logic [3:0]  ctls [7];

  initial begin
    ex.in_valid = 1'b0; ex.flush = 1'b0; ex.out_ready = 1'b1;
    ex.branch = 1'b0; ex.memread = 1'b0; ex.memwrite = 1'b0; ex.memtoreg = 1'b0; ex.regwrite = 1'b0;
    ex.pc4 = 32'd0; ex.alusrc = 1'b0; ex.data1 = 32'd0; ex.data2 = 32'd0; ex.seimm = 32'd0;
    ex.aluctl = 4'd0; ex.mdu_op = 3'd0; ex.regdst = 1'b0; ex.rt = 5'd0; ex.rd = 5'd0;
    tick(); tick();
    chk("rst_out_valid", ex.out_valid, 1'b0);
    chk("rst_alurslt", ex.alurslt, 32'd0);
    chk("rst_busy", ex.mdu_busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // ADD 5+7, rd=9
    setup(3'd0, 4'd2, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 1'b1, 5'd9);
    tick(); ex.in_valid = 1'b0;
    chk("add_valid", ex.out_valid, 1'b1);
    chk("add_rslt", ex.alurslt, 32'd12);
    chk("add_zero", ex.zero, 1'b0);
    chk("add_wrreg", ex.wrreg_out, 5'd9);

    // Branch target with negative offset, SUB 3-3
    setup(3'd0, 4'd6, 32'd3, 32'd3, 1'b0, 32'hFFFF_FFFF, 32'h100, 1'b0, 5'd9);
    tick(); ex.in_valid = 1'b0;
    chk("br_target", ex.btarget, 32'h0000_00FC);
    chk("sub_zero", ex.zero, 1'b1);
    chk("rt_select", ex.wrreg_out, 5'd3);

    // Immediate operand: 10 + (-2)
    setup(3'd0, 4'd2, 32'd10, 32'd99, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b1, 5'd4);
    tick(); ex.in_valid = 1'b0;
    chk("imm_add", ex.alurslt, 32'd8);

    // ALU table through the model
    ctls = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd15};
    foreach (ctls[i]) issue(3'd0, ctls[i], 32'h8000_0001, 32'h7FFF_FFFF);
    tick();

    // Stall: hold A while B waits
    ex.out_ready = 1'b0;
    issue(3'd0, 4'd1, 32'h0000_00F0, 32'h0000_000F);
    chk("stall_a", ex.alurslt, 32'h0000_00FF);
    setup(3'd0, 4'd0, 32'h0000_00FF, 32'h0000_003C, 1'b0, 32'd0, 32'd0, 1'b1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", ex.in_ready, 1'b0);
      tick();
      chk("stall_hold", ex.alurslt, 32'h0000_00FF);
    end
    ex.out_ready = 1'b1; #1;
    chk("stall_release", ex.in_ready, 1'b1);
    tick(); ex.in_valid = 1'b0;
    chk("stall_b", ex.alurslt, 32'h0000_003C);
    tick();

    // MULTU 0xFFFFFFFF*2 with MFHI waiting behind it
    issue(3'd1, 4'd2, 32'hFFFF_FFFF, 32'd2);
    chk("mul_busy", ex.mdu_busy, 1'b1);
    setup(3'd3, 4'd2, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd8);
    n = 0;
    while (ex.mdu_busy === 1'b1 && n < 100) begin
      chk("mfhi_held", ex.in_ready, 1'b0);
      tick();
      n++;
    end
    chk("mul_cycles", n, 32);
    chk("mfhi_ready", ex.in_ready, 1'b1);
    tick(); ex.in_valid = 1'b0;
    chk("mul_hi", ex.alurslt, 32'd1);
    issue(3'd4, 4'd2, 32'd0, 32'd0);
    chk("mul_lo", ex.alurslt, 32'hFFFF_FFFE);

    // DIVU 7/0 and 100/7
    issue(3'd2, 4'd2, 32'd7, 32'd0); wait_idle(n);
    issue(3'd3, 4'd2, 32'd0, 32'd0); chk("div0_hi", ex.alurslt, 32'd7);
    issue(3'd4, 4'd2, 32'd0, 32'd0); chk("div0_lo", ex.alurslt, 32'hFFFF_FFFF);
    issue(3'd2, 4'd2, 32'd100, 32'd7); wait_idle(n);
    chk("div_cycles", n, 32);
    issue(3'd4, 4'd2, 32'd0, 32'd0); chk("div_lo", ex.alurslt, 32'd14);
    issue(3'd3, 4'd2, 32'd0, 32'd0); chk("div_hi", ex.alurslt, 32'd2);

    // Flushed MULTU never starts
    ex.flush = 1'b1;
    issue(3'd1, 4'd2, 32'd3, 32'd5);
    ex.flush = 1'b0;
    chk("flush_valid", ex.out_valid, 1'b0);
    chk("flush_busy", ex.mdu_busy, 1'b0);
    issue(3'd3, 4'd2, 32'd0, 32'd0); chk("flush_hi_kept", ex.alurslt, 32'd2);

    // More MDU vectors, checked by the model
    mv = '{32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'h0000_0010, 32'd5, 32'd9};
    for (int i = 0; i < 4; i++) begin
      issue((i < 2) ? 3'd1 : 3'd2, 4'd2, mv[2*i], mv[2*i+1]); wait_idle(n);
      issue(3'd3, 4'd2, 32'd0, 32'd0);
      issue(3'd4, 4'd2, 32'd0, 32'd0);
    end

    // Reset in the middle of a DIVU
    issue(3'd2, 4'd2, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0; #1;
    chk("rst_mid_busy", ex.mdu_busy, 1'b0);
    chk("rst_mid_valid", ex.out_valid, 1'b0);
    tick(); rst_n = 1'b1; tick();
    issue(3'd3, 4'd2, 32'd0, 32'd0); chk("rst_hi", ex.alurslt, 32'd0);
    issue(3'd4, 4'd2, 32'd0, 32'd0); chk("rst_lo", ex.alurslt, 32'd0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
